dco_div: RTL and testbench

- Parametrised digitally controlled divider for the DPLL loop; it produces the recovered clock from the system clock.
- Divide ratio is programmable at run time through a shadow register. The new ratio takes effect only at a terminal count, so the output never has a runt half-period.
- A per-cycle phase command (normal / advance / retard) lets the phase detector and loop filter slew the output phase.
- Adds registered edge strobes and a ratio-update acknowledge.

---
 rtl/dpll_pkg.sv | 12 +
 rtl/dco_div_if.sv | 30 +++
 rtl/dco_ratio_shadow.sv | 57 +++++
 rtl/dco_div.sv | 90 +++++++++
 tb/tb_dco_div.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dpll_pkg.sv
// Shared DPLL definitions.
//   OFS_*  : encodings of the per-cycle phase command (3 is treated as normal).
//   DPLL_W : default counter / divide-ratio width.
package dpll_pkg;

    localparam logic [1:0] OFS_NORMAL = 2'd0;
    localparam logic [1:0] OFS_ADV    = 2'd1;
    localparam logic [1:0] OFS_HOLD   = 2'd2;

    localparam int unsigned DPLL_W = 32;

endpackage

// File: rtl/dco_div_if.sv
// Control/status bundle of the DCO divider.
//   clr, offset, n_wr, n_in        : commands from the loop (master -> slave)
//   n_ack, n_pend, n_cur           : ratio update status
//   clk_out, rise, fall            : divided clock and its edge strobes
interface dco_div_if #(
    parameter int unsigned W = 32
) ();

    logic         clr;
    logic [1:0]   offset;
    logic         n_wr;
    logic [W-1:0] n_in;
    logic         n_ack;
    logic         n_pend;
    logic [W-1:0] n_cur;
    logic         clk_out;
    logic         rise;
    logic         fall;

    modport master (
        output clr, offset, n_wr, n_in,
        input  n_ack, n_pend, n_cur, clk_out, rise, fall
    );

    modport slave (
        input  clr, offset, n_wr, n_in,
        output n_ack, n_pend, n_cur, clk_out, rise, fall
    );

endinterface

// File: rtl/dco_ratio_shadow.sv
// Divide-ratio shadow register.
//   clk, reset_n     : system clock, async active-low reset
//   n_wr, n_in       : capture strobe and requested ratio
//   terminal_or_clr  : apply point (divider terminal count or clear)
//   n_cur            : ratio in force
//   n_pend           : a captured ratio is waiting for an apply point
//   n_ack            : one-cycle pulse when the pending ratio takes effect
module dco_ratio_shadow
    import dpll_pkg::*;
#(
    parameter int unsigned W       = DPLL_W,
    parameter int unsigned N_RESET = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         n_wr,
    input  logic [W-1:0] n_in,
    input  logic         terminal_or_clr,
    output logic [W-1:0] n_cur,
    output logic         n_pend,
    output logic         n_ack
);

    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] n_cur_q, n_cur_d;
    logic         pend_q, pend_d;
    logic         ack_q, ack_d;
    logic         apply_now;

    always_comb begin
        apply_now = terminal_or_clr && pend_q;
        shadow_d  = n_wr ? n_in : shadow_q;
        // The old registered shadow is applied; a coincident write stays pending.
        n_cur_d   = apply_now ? shadow_q : n_cur_q;
        pend_d    = n_wr || (pend_q && !apply_now);
        ack_d     = apply_now;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_q <= W'(N_RESET);
            n_cur_q  <= W'(N_RESET);
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            n_cur_q  <= n_cur_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
        end
    end

    assign n_cur  = n_cur_q;
    assign n_pend = pend_q;
    assign n_ack  = ack_q;

endmodule

// File: rtl/dco_div.sv
// Digitally controlled divider producing the DPLL recovered clock.
//   clk, reset_n : system clock, async active-low reset
//   bus (slave)  : clr/offset phase commands, n_wr/n_in ratio writes,
//                  n_cur/n_pend/n_ack ratio status, clk_out with rise/fall strobes
// Half-period is n_cur counts; offset slews phase (advance adds ADV_STEP, hold adds 0).
module dco_div
    import dpll_pkg::*;
#(
    parameter int unsigned W        = DPLL_W,
    parameter int unsigned ADV_STEP = 5,
    parameter int unsigned N_RESET  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    dco_div_if.slave   bus
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         clk_out_q, clk_out_d;
    logic         rise_q, rise_d;
    logic         fall_q, fall_d;
    logic [W-1:0] step;
    logic [W:0]   sum;
    logic         terminal;
    logic [W-1:0] n_cur;

    dco_ratio_shadow #(
        .W       (W),
        .N_RESET (N_RESET)
    ) u_shadow (
        .clk             (clk),
        .reset_n         (reset_n),
        .n_wr            (bus.n_wr),
        .n_in            (bus.n_in),
        .terminal_or_clr (terminal || bus.clr),
        .n_cur           (n_cur),
        .n_pend          (bus.n_pend),
        .n_ack           (bus.n_ack)
    );

    always_comb begin
        case (bus.offset)
            OFS_ADV:  step = W'(ADV_STEP);
            OFS_HOLD: step = '0;
            default:  step = W'(1);
        endcase
        // One extra bit so cnt+step never wraps below n_cur.
        sum      = {1'b0, cnt_q} + {1'b0, step};
        // n_cur=0 makes every non-hold cycle terminal, same as n_cur=1.
        terminal = !bus.clr && (step != '0) && (sum >= {1'b0, n_cur});

        cnt_d     = cnt_q;
        clk_out_d = clk_out_q;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        if (bus.clr) begin
            cnt_d     = '0;
            clk_out_d = 1'b0;
            fall_d    = clk_out_q;
        end else if (terminal) begin
            // Overshoot past n_cur is dropped, not carried.
            cnt_d     = '0;
            clk_out_d = !clk_out_q;
            rise_d    = !clk_out_q;
            fall_d    = clk_out_q;
        end else if (step != '0) begin
            cnt_d = sum[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            rise_q    <= 1'b0;
            fall_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
        end
    end

    assign bus.n_cur   = n_cur;
    assign bus.clk_out = clk_out_q;
    assign bus.rise    = rise_q;
    assign bus.fall    = fall_q;

endmodule

// File: tb/tb_dco_div.sv
module tb_dco_div;

    localparam int unsigned W   = 32;
    localparam int unsigned ADV = 5;
    localparam int unsigned NR  = 8;

    logic clk;
    logic reset_n;

    dco_div_if #(.W(W)) bus ();

    dco_div #(
        .W        (W),
        .ADV_STEP (ADV),
        .N_RESET  (NR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: phase accumulated within the current half-period, output level,
    // ratio in force and a one-deep pending ratio.
    longint unsigned m_acc, m_ratio, m_shadow;
    bit              m_lvl, m_rise, m_fall, m_ack, m_pend;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_ratio = NR; m_shadow = NR; m_lvl = 0;
        m_rise = 0; m_fall = 0; m_ack = 0; m_pend = 0;
    endtask

    task automatic model_step(input bit c, input bit [1:0] o, input bit w,
                              input longint unsigned nin);
        longint unsigned adv;
        bit apply;
        adv    = (o == 2'd1) ? longint'(ADV) : (o == 2'd2) ? 0 : 1;
        apply  = 0;
        m_rise = 0; m_fall = 0; m_ack = 0;
        if (c) begin
            m_fall = m_lvl;
            m_lvl  = 0;
            m_acc  = 0;
            apply  = 1;
        end else if (adv != 0) begin
            m_acc += adv;
            if (m_acc >= m_ratio) begin
                m_acc  = 0;
                m_lvl  = !m_lvl;
                m_rise = m_lvl;
                m_fall = !m_lvl;
                apply  = 1;
            end
        end
        if (apply && m_pend) begin
            m_ratio = m_shadow;
            m_pend  = 0;
            m_ack   = 1;
        end
        if (w) begin
            m_shadow = nin;
            m_pend   = 1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".clk_out"}, bus.clk_out, m_lvl);
        chk({tag, ".rise"},    bus.rise,    m_rise);
        chk({tag, ".fall"},    bus.fall,    m_fall);
        chk({tag, ".n_cur"},   bus.n_cur,   m_ratio);
        chk({tag, ".n_pend"},  bus.n_pend,  m_pend);
        chk({tag, ".n_ack"},   bus.n_ack,   m_ack);
    endtask

    // One clock: inputs are applied away from the edge, outputs sampled on negedge.
    task automatic cyc(input string tag, input bit c, input bit [1:0] o, input bit w,
                       input logic [W-1:0] nin);
        bus.clr    = c;
        bus.offset = o;
        bus.n_wr   = w;
        bus.n_in   = nin;
        @(posedge clk);
        model_step(c, o, w, longint'(nin));
        @(negedge clk);
        check_model(tag);
        bus.clr  = 1'b0;
        bus.n_wr = 1'b0;
    endtask

    // Normal cycles until a rise (want_rise=1) or fall; n = cycles taken.
    task automatic run_to(input string tag, input bit want_rise, output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            cyc(tag, 1'b0, 2'd0, 1'b0, '0);
            n++;
            if (want_rise ? bus.rise : bus.fall) return;
        end
        chk({tag, ".timeout"}, 64'd0, 64'd1);
    endtask

    int n, rises, falls, first_rise, toggles;
    bit big;

    initial begin
        reset_n    = 1'b0;
        bus.clr    = 1'b0;
        bus.offset = 2'd0;
        bus.n_wr   = 1'b0;
        bus.n_in   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_model("reset");

        // Free run at N_RESET.
        reset_n    = 1'b1;
        rises      = 0;
        falls      = 0;
        first_rise = 0;
        for (int i = 1; i <= 64; i++) begin
            cyc("run", 1'b0, 2'd0, 1'b0, '0);
            if (bus.rise) begin
                rises++;
                if (first_rise == 0) first_rise = i;
            end
            if (bus.fall) falls++;
        end
        chk("first_rise", first_rise, 8);
        chk("rises64", rises, 4);
        chk("falls64", falls, 4);

        // Single advance at cnt=2 shortens the half-period to 4.
        cyc("adv", 1'b0, 2'd0, 1'b0, '0);
        cyc("adv", 1'b0, 2'd0, 1'b0, '0);
        cyc("adv", 1'b0, 2'd1, 1'b0, '0);
        run_to("adv", 1'b1, n);
        chk("adv_half", 3 + n, 4);
        run_to("adv_next", 1'b0, n);
        chk("adv_next_half", n, 8);

        // Hold 10 cycles mid-half-period: completes 10 cycles late.
        repeat (3) cyc("hold", 1'b0, 2'd0, 1'b0, '0);
        repeat (10) cyc("hold", 1'b0, 2'd2, 1'b0, '0);
        run_to("hold", 1'b1, n);
        chk("hold_half", 13 + n, 18);

        // Two writes while pending: latest wins, one ack.
        repeat (4) cyc("wr", 1'b0, 2'd0, 1'b0, '0);
        cyc("wr", 1'b0, 2'd0, 1'b1, 32'd3);
        cyc("wr", 1'b0, 2'd0, 1'b0, '0);
        cyc("wr", 1'b0, 2'd0, 1'b1, 32'd5);
        chk("wr_pend", bus.n_pend, 1);
        chk("wr_cur_old", bus.n_cur, 8);
        cyc("wr", 1'b0, 2'd0, 1'b0, '0);
        chk("wr_fall", bus.fall, 1);
        chk("wr_cur_new", bus.n_cur, 5);
        chk("wr_ack", bus.n_ack, 1);
        run_to("wr5", 1'b1, n);
        chk("wr5_half", n, 5);

        // Write coinciding with an applying terminal stays pending.
        cyc("coin", 1'b0, 2'd0, 1'b1, 32'd6);
        repeat (3) cyc("coin", 1'b0, 2'd0, 1'b0, '0);
        cyc("coin", 1'b0, 2'd0, 1'b1, 32'd10);
        chk("coin_fall", bus.fall, 1);
        chk("coin_cur", bus.n_cur, 6);
        chk("coin_ack", bus.n_ack, 1);
        chk("coin_pend", bus.n_pend, 1);
        run_to("coin6", 1'b1, n);
        chk("coin6_half", n, 6);
        chk("coin_cur10", bus.n_cur, 10);
        chk("coin_ack10", bus.n_ack, 1);
        chk("coin_pend0", bus.n_pend, 0);

        // Clear while high at cnt=5.
        repeat (5) cyc("clr", 1'b0, 2'd0, 1'b0, '0);
        chk("clr_pre_hi", bus.clk_out, 1);
        cyc("clr", 1'b1, 2'd0, 1'b0, '0);
        chk("clr_lo", bus.clk_out, 0);
        chk("clr_fall", bus.fall, 1);
        run_to("clr_after", 1'b1, n);
        chk("clr_restart", n, 10);

        // Asynchronous reset mid-half-period, no clock edge needed.
        repeat (3) cyc("arst", 1'b0, 2'd0, 1'b0, '0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_model("arst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        run_to("arst_rel", 1'b1, n);
        chk("arst_first_rise", n, 8);

        // n_cur=0: toggles every non-hold cycle; hold still freezes it.
        cyc("n0", 1'b0, 2'd0, 1'b1, '0);
        cyc("n0", 1'b1, 2'd0, 1'b0, '0);
        chk("n0_cur", bus.n_cur, 0);
        chk("n0_ack", bus.n_ack, 1);
        toggles = 0;
        for (int i = 0; i < 6; i++) begin
            cyc("n0run", 1'b0, (i == 3) ? 2'd1 : 2'd0, 1'b0, '0);
            toggles += int'(bus.rise) + int'(bus.fall);
        end
        chk("n0_toggles", toggles, 6);
        toggles = 0;
        for (int i = 0; i < 5; i++) begin
            cyc("n0hold", 1'b0, 2'd2, 1'b0, '0);
            toggles += int'(bus.rise) + int'(bus.fall);
        end
        chk("n0_hold_toggles", toggles, 0);

        // Random traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            big = ($urandom_range(0, 49) == 0);
            cyc("rand", $urandom_range(0, 99) < 2, 2'($urandom_range(0, 3)),
                $urandom_range(0, 19) == 0,
                big ? 32'hFFFF_FFFF : 32'($urandom_range(0, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
